md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. Sits in the E stage beside the ALU.
- Driven by the 4-bit HI/LO operation code produced by the control unit.
- Raises busy so that the hazard logic stalls later HI/LO instructions in D.
- Successor to the fixed single-width HI/LO path: width and latencies are parametrised, results are deterministic for divide-by-zero and overflow, and exception flush is supported.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-12 reserved for the optional feature.
- start  input  1  E-stage instruction valid; op is sampled only when start=1.
- flush  input  1  exception/eret flush; kills the E-stage op and aborts any in-flight op.
- rs_data  input  WIDTH  forwarded rs value (dividend / multiplicand / mt source).
- rt_data  input  WIDTH  forwarded rt value (divisor / multiplier).
- busy  output  1  an operation is in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd_data  output  WIDTH  combinational: hi when op=5, lo when op=6, otherwise 0.

Behaviour:
- Reset: hi=0, lo=0, busy=0, cycle counter=0, pending result discarded.
- States: IDLE, RUN.
- IDLE to RUN: at the edge where start=1, flush=0, busy=0 and op is in 1..4.
  - Operands are latched, the result is computed into shadow registers, and the counter is loaded with MULT_CYCLES or DIV_CYCLES.
- Timing: with start sampled at edge 0, busy=1 during cycles 1..N. At the edge ending cycle N, hi/lo take the shadow result, busy drops to 0, and state returns to IDLE. New values are visible in cycle N+1.
- mthi/mtlo (op 7/8) with start=1, flush=0, busy=0: hi or lo <= rs_data at the next edge. busy stays 0.
- mfhi/mflo: no state change; rd_data gives the current register value with no latency.
- Start while busy=1 is a protocol violation and is ignored; hi/lo and the counter are unaffected. Simulation-only error message.
- flush=1 has priority over everything:
  - In IDLE, start is ignored (including mt).
  - In RUN, state goes to IDLE at the next edge, busy=0 from the next cycle, and hi/lo keep their pre-operation values.
- Arithmetic:
  - mult/multu: full 2*WIDTH product, signed or unsigned; HI=upper half, LO=lower half.
  - div/divu: LO=quotient truncated toward zero; HI=remainder, which takes the sign of the dividend.
  - Divide by zero (signed or unsigned): LO={WIDTH{1}}, HI=rs_data.
  - Signed overflow (-2^(WIDTH-1) / -1): LO=-2^(WIDTH-1), HI=0.
- reset mid-operation: returns to the reset values at that edge; the result is discarded.
- Reserved ops 9-15 without the feature: treated as none. No state change, busy stays 0.

Optional Feature:
- MD_MADD_EN:
  - Defined: ops 9 madd, 10 maddu, 11 msub, 12 msubu are enabled, each with MULT_CYCLES latency.
  - {HI,LO} <= {HI,LO} +/- product (signed or unsigned), modulo 2^(2*WIDTH).
  - The accumulate uses the HI/LO values captured at start.
  - Not defined: ops 9-12 behave as none.

Test Plan:
- mult, rs=0xFFFFFFFF, rt=2 -> busy=1 in cycles 1..5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- multu, same operands -> cycle 6: hi=0x00000001, lo=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (-7), rt=2 -> busy during cycles 1..10; cycle 11: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu, rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- Flush and mt/mf:
  - mthi rs=0x12345678, then mult 3*4 with flush asserted in busy cycle 3 -> busy=0 from cycle 4, hi=0x12345678, lo unchanged.
  - mflo in the following cycle -> rd_data=lo.
- MD_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then maddu 1*1 -> hi=1, lo=0. Same sequence without the macro -> hi/lo unchanged, busy never asserted.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional multiply-accumulate ops 9-12 are enabled by defining MD_MADD_EN.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N  = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N   = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]  sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

    logic accept, launch, is_mul, is_div, is_acc, mul_signed, done;

    assign accept = start && !flush && (state_q == S_IDLE);
    assign is_mul = (op == 4'd1) || (op == 4'd2);
    assign is_div = (op == 4'd3) || (op == 4'd4);
`ifdef MD_MADD_EN
    assign is_acc = (op >= 4'd9) && (op <= 4'd12);
`else
    assign is_acc = 1'b0;
`endif
    assign mul_signed = (op == 4'd1) || (op == 4'd9) || (op == 4'd11);
    assign launch = accept && (is_mul || is_div || is_acc);

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    assign a_ext = {{WIDTH{mul_signed & rs_data[WIDTH-1]}}, rs_data};
    assign b_ext = {{WIDTH{mul_signed & rt_data[WIDTH-1]}}, rt_data};
    assign prod  = a_ext * b_ext;

    logic div_zero, div_ovf;
    logic [WIDTH-1:0] rt_safe, q_u, r_u, q_s, r_s;
    logic signed [WIDTH-1:0] s_rs, s_rt;
    assign div_zero = (rt_data == '0);
    assign div_ovf  = (op == 4'd3) && (rs_data == SMIN) && (rt_data == '1);
    // The divider never sees the trap operands; those cases are muxed in below.
    assign rt_safe  = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : rt_data;
    assign s_rs = $signed(rs_data);
    assign s_rt = $signed(rt_safe);
    assign q_u  = rs_data / rt_safe;
    assign r_u  = rs_data % rt_safe;
    assign q_s  = s_rs / s_rt;
    assign r_s  = s_rs % s_rt;

    logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MD_MADD_EN
    logic [2*WIDTH-1:0] acc;
    assign acc = (op <= 4'd10) ? ({hi_q, lo_q} + prod) : ({hi_q, lo_q} - prod);
`endif
    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = rs_data;
                res_lo = '1;
            end else if (div_ovf) begin
                res_hi = '0;
                res_lo = SMIN;
            end else if (op == 4'd3) begin
                res_hi = r_s;
                res_lo = q_s;
            end else begin
                res_hi = r_u;
                res_lo = q_u;
            end
        end
`ifdef MD_MADD_EN
        if (is_acc) begin
            res_hi = acc[2*WIDTH-1:WIDTH];
            res_lo = acc[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN:   if (flush || cnt_q == CNT_ONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_RUN) && !flush && (cnt_q == CNT_ONE);
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        cnt_d   = cnt_q;
        if (launch) begin
            sh_hi_d = res_hi;
            sh_lo_d = res_lo;
            cnt_d   = is_div ? DIV_N : MULT_N;
        end else if (accept && op == 4'd7) begin
            hi_d = rs_data;
        end else if (accept && op == 4'd8) begin
            lo_d = rs_data;
        end
        if (state_q == S_RUN) begin
            cnt_d = flush ? '0 : cnt_q - CNT_ONE;
            if (done) begin
                hi_d = sh_hi_q;
                lo_d = sh_lo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    always_comb begin
        case (op)
            4'd5:    rd_data = hi_q;
            4'd6:    rd_data = lo_q;
            default: rd_data = '0;
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

`ifndef SYNTHESIS
    // A started HI/LO op while busy means the hazard logic failed to stall.
    always_ff @(posedge clk) begin
        if (!reset && start && !flush && busy && op != 4'd0)
            $warning("md_unit: start with op %0d while busy ignored", op);
    end
`endif
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vectors plus randomized ops against
// an arithmetic reference model of HI/LO.
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [3:0]   op;
    logic [W-1:0] rs_data, rt_data;
    logic         busy;
    logic [W-1:0] hi, lo, rd_data;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] hi_m, lo_m;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: HI/LO after an accepted op, plus its expected busy length.
    task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int n);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] p, t, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        n = 0;
        case (o)
            4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; n = MC; end
            4'd2: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; n = MC; end
            4'd3, 4'd4: begin
                n = DC;
                if (b == 32'd0) begin
                    hi_m = a;
                    lo_m = 32'hFFFF_FFFF;
                end else if (o == 4'd3) begin
                    sq = sa / sb; sr = sa % sb;
                    t = sq; lo_m = t[31:0];
                    t = sr; hi_m = t[31:0];
                end else begin
                    t = ua / ub; lo_m = t[31:0];
                    t = ua % ub; hi_m = t[31:0];
                end
            end
            4'd7: hi_m = a;
            4'd8: lo_m = a;
`ifdef MD_MADD_EN
            4'd9, 4'd10, 4'd11, 4'd12: begin
                if (o == 4'd9 || o == 4'd11) p = sa * sb;
                else p = ua * ub;
                acc = {hi_m, lo_m};
                acc = (o <= 4'd10) ? acc + p : acc - p;
                hi_m = acc[63:32];
                lo_m = acc[31:0];
                n = MC;
            end
`endif
            default: ;
        endcase
    endtask

    // Issue one op at edge 0, then count busy cycles from cycle 1; returns in cycle nb+1.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nb);
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        $display("[TB] op=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d", o, a, b, hi, lo, nb);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 4'd1; flush = 1'b0;
        rs_data = 32'hFFFF_FFFF; rt_data = 32'd3;
        repeat (3) @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++;
        if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got=%h exp=0", hi); end
        tests_run++;
        if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic check_vec(input string name, input logic [3:0] o,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n);
        int nb;
        do_op(o, a, b, nb);
        tests_run++;
        if (nb != exp_n) begin tests_failed++; $display("FAIL %s_busy got=%0d exp=%0d", name, nb, exp_n); end
        tests_run++;
        if (hi !== exp_hi) begin tests_failed++; $display("FAIL %s_hi got=%h exp=%h", name, hi, exp_hi); end
        tests_run++;
        if (lo !== exp_lo) begin tests_failed++; $display("FAIL %s_lo got=%h exp=%h", name, lo, exp_lo); end
    endtask

    task automatic test_mult();
        int n;
        check_vec("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC);
        check_vec("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MC);
        model_apply(4'd2, 32'hFFFF_FFFF, 32'd2, n);
    endtask

    task automatic test_div();
        int n;
        check_vec("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        check_vec("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC);
        check_vec("divu_zero", 4'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DC);
        check_vec("div_zero", 4'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DC);
        check_vec("divu_big", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, DC);
        model_apply(4'd4, 32'hFFFF_FFF9, 32'd2, n);
    endtask

    task automatic test_mt_flush();
        int n;
        logic [31:0] lo_before;
        check_vec("mthi", 4'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, lo_m, 0);
        model_apply(4'd7, 32'h1234_5678, 32'd0, n);
        lo_before = lo_m;
        @(negedge clk);
        op = 4'd1; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
        @(negedge clk);                 // cycle 1
        start = 1'b0; op = 4'd0;
        @(negedge clk);                 // cycle 2
        @(negedge clk);                 // cycle 3
        flush = 1'b1;
        @(negedge clk);                 // cycle 4
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got=%b exp=0", busy); end
        repeat (4) @(negedge clk);
        tests_run++;
        if (hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL flush_hi got=%h exp=12345678", hi); end
        tests_run++;
        if (lo !== lo_before) begin tests_failed++; $display("FAIL flush_lo got=%h exp=%h", lo, lo_before); end
        op = 4'd6; #1;
        tests_run++;
        if (rd_data !== lo_m) begin tests_failed++; $display("FAIL mflo got=%h exp=%h", rd_data, lo_m); end
        op = 4'd5; #1;
        tests_run++;
        if (rd_data !== hi_m) begin tests_failed++; $display("FAIL mfhi got=%h exp=%h", rd_data, hi_m); end
        op = 4'd0; #1;
        tests_run++;
        if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL rd_none got=%h exp=0", rd_data); end
        // A flushed mtlo in IDLE must not write.
        @(negedge clk);
        op = 4'd8; rs_data = 32'hCAFE_F00D; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        op = 4'd0; start = 1'b0; flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if (lo !== lo_m) begin tests_failed++; $display("FAIL flush_mt got=%h exp=%h", lo, lo_m); end
    endtask

    task automatic test_busy_ignore();
        int nb, n;
        model_apply(4'd3, 32'd1000, 32'd7, n);
        @(negedge clk);
        op = 4'd3; rs_data = 32'd1000; rt_data = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            if (nb == 2) begin start = 1'b1; op = 4'd7; rs_data = 32'hDEAD_BEEF; end
            else if (nb == 5) begin start = 1'b1; op = 4'd1; rs_data = 32'd9; rt_data = 32'd9; end
            else begin start = 1'b0; op = 4'd0; end
            @(negedge clk);
        end
        start = 1'b0; op = 4'd0;
        tests_run++;
        if (nb != n) begin tests_failed++; $display("FAIL ignore_busy got=%0d exp=%0d", nb, n); end
        tests_run++;
        if (hi !== hi_m) begin tests_failed++; $display("FAIL ignore_hi got=%h exp=%h", hi, hi_m); end
        tests_run++;
        if (lo !== lo_m) begin tests_failed++; $display("FAIL ignore_lo got=%h exp=%h", lo, lo_m); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = 4'd2; rs_data = 32'd77; rt_data = 32'd88; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        repeat (6) @(negedge clk);
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0)
            begin tests_failed++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
    endtask

    task automatic test_reserved_madd();
        int nb, n;
        do_op(4'd7, 32'd0, 32'd0, nb);
        model_apply(4'd7, 32'd0, 32'd0, n);
        do_op(4'd8, 32'hFFFF_FFFF, 32'd0, nb);
        model_apply(4'd8, 32'hFFFF_FFFF, 32'd0, n);
        do_op(4'd10, 32'd1, 32'd1, nb);
        model_apply(4'd10, 32'd1, 32'd1, n);
        tests_run++;
        if (nb != n) begin tests_failed++; $display("FAIL maddu_busy got=%0d exp=%0d", nb, n); end
        tests_run++;
        if (hi !== hi_m || lo !== lo_m)
            begin tests_failed++; $display("FAIL maddu_hilo got=%h_%h exp=%h_%h", hi, lo, hi_m, lo_m); end
        for (int k = 13; k <= 15; k++) begin
            do_op(4'(k), $urandom, $urandom, nb);
            tests_run++;
            if (nb != 0 || hi !== hi_m || lo !== lo_m)
                begin tests_failed++; $display("FAIL reserved_%0d got=%0d/%h_%h exp=0/%h_%h", k, nb, hi, lo, hi_m, lo_m); end
        end
    endtask

    task automatic test_random();
        logic [3:0] pool [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0, 4'd3};
        logic [3:0] o;
        logic [31:0] a, b;
        int nb, n;
        for (int i = 0; i < 60; i++) begin
            o = pool[$urandom_range(0, 11)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                default: ;
            endcase
            do_op(o, a, b, nb);
            model_apply(o, a, b, n);
            tests_run++;
            if (nb != n || hi !== hi_m || lo !== lo_m)
                begin tests_failed++; $display("FAIL rand_%0d op=%0d got=%0d/%h_%h exp=%0d/%h_%h", i, o, nb, hi, lo, n, hi_m, lo_m); end
            op = 4'd6; #1;
            tests_run++;
            if (rd_data !== lo_m) begin tests_failed++; $display("FAIL rand_mflo_%0d got=%h exp=%h", i, rd_data, lo_m); end
            op = 4'd0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0;
        rs_data = '0; rt_data = '0;
        test_reset();
        test_mult();
        test_div();
        test_mt_flush();
        test_busy_ignore();
        test_reset_mid();
        test_reserved_madd();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
